// File: rtl/axi_ddr3_arbiter.sv
// Two-port AXI4 arbiter in front of a single DDR3 controller port.
// Write and read paths each own a round-robin FSM and allow one outstanding transaction.
module axi_ddr3_arbiter #(
    parameter int AXI_ID_WIDTH = 4,
    parameter int ADDR_WIDTH   = 27,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    // upstream port 0
    input  logic                    s0_awvalid,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [AXI_ID_WIDTH-1:0] s0_awid,
    input  logic [7:0]              s0_awlen,
    input  logic [1:0]              s0_awburst,
    output logic                    s0_awready,
    input  logic                    s0_wvalid,
    input  logic                    s0_wlast,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    output logic                    s0_wready,
    output logic                    s0_bvalid,
    output logic [1:0]              s0_bresp,
    output logic [AXI_ID_WIDTH-1:0] s0_bid,
    input  logic                    s0_bready,
    input  logic                    s0_arvalid,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [AXI_ID_WIDTH-1:0] s0_arid,
    input  logic [7:0]              s0_arlen,
    input  logic [1:0]              s0_arburst,
    output logic                    s0_arready,
    output logic                    s0_rvalid,
    output logic                    s0_rlast,
    output logic [1:0]              s0_rresp,
    output logic [AXI_ID_WIDTH-1:0] s0_rid,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    input  logic                    s0_rready,
    // upstream port 1
    input  logic                    s1_awvalid,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [AXI_ID_WIDTH-1:0] s1_awid,
    input  logic [7:0]              s1_awlen,
    input  logic [1:0]              s1_awburst,
    output logic                    s1_awready,
    input  logic                    s1_wvalid,
    input  logic                    s1_wlast,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    output logic                    s1_wready,
    output logic                    s1_bvalid,
    output logic [1:0]              s1_bresp,
    output logic [AXI_ID_WIDTH-1:0] s1_bid,
    input  logic                    s1_bready,
    input  logic                    s1_arvalid,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [AXI_ID_WIDTH-1:0] s1_arid,
    input  logic [7:0]              s1_arlen,
    input  logic [1:0]              s1_arburst,
    output logic                    s1_arready,
    output logic                    s1_rvalid,
    output logic                    s1_rlast,
    output logic [1:0]              s1_rresp,
    output logic [AXI_ID_WIDTH-1:0] s1_rid,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    input  logic                    s1_rready,
    // downstream port to the DDR3 core
    output logic                    m_awvalid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [AXI_ID_WIDTH-1:0] m_awid,
    output logic [7:0]              m_awlen,
    output logic [1:0]              m_awburst,
    input  logic                    m_awready,
    output logic                    m_wvalid,
    output logic                    m_wlast,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic                    m_wready,
    input  logic                    m_bvalid,
    input  logic [1:0]              m_bresp,
    input  logic [AXI_ID_WIDTH-1:0] m_bid,
    output logic                    m_bready,
    output logic                    m_arvalid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [AXI_ID_WIDTH-1:0] m_arid,
    output logic [7:0]              m_arlen,
    output logic [1:0]              m_arburst,
    input  logic                    m_arready,
    input  logic                    m_rvalid,
    input  logic                    m_rlast,
    input  logic [1:0]              m_rresp,
    input  logic [AXI_ID_WIDTH-1:0] m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    m_rready,
    output logic [1:0]              wr_gnt_o,
    output logic [1:0]              rd_gnt_o
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t   w_state, w_next;
    r_state_t   r_state, r_next;
    logic [1:0] wr_gnt, wr_gnt_next, rd_gnt, rd_gnt_next;
    // last-winner pointers: 1 means port 1 won most recently
    logic       wr_last, wr_last_next, rd_last, rd_last_next;
    logic       wr_pick, rd_pick, wr_sel, rd_sel;

    assign wr_pick = (s0_awvalid && s1_awvalid) ? ~wr_last : s1_awvalid;
    assign rd_pick = (s0_arvalid && s1_arvalid) ? ~rd_last : s1_arvalid;
    assign wr_sel  = wr_gnt[1];
    assign rd_sel  = rd_gnt[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            wr_gnt  <= 2'b00;
            rd_gnt  <= 2'b00;
            wr_last <= 1'b1;
            rd_last <= 1'b1;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            wr_gnt  <= wr_gnt_next;
            rd_gnt  <= rd_gnt_next;
            wr_last <= wr_last_next;
            rd_last <= rd_last_next;
        end
    end

    always_comb begin
        w_next       = w_state;
        wr_gnt_next  = wr_gnt;
        wr_last_next = wr_last;
        case (w_state)
            W_IDLE: if (s0_awvalid || s1_awvalid) begin
                w_next       = W_ADDR;
                wr_gnt_next  = wr_pick ? 2'b10 : 2'b01;
                wr_last_next = wr_pick;
            end
            W_ADDR: if (m_awvalid && m_awready) w_next = W_DATA;
            W_DATA: if (m_wvalid && m_wready && m_wlast) w_next = W_RESP;
            W_RESP: if (m_bvalid && m_bready) begin
                w_next      = W_IDLE;
                wr_gnt_next = 2'b00;
            end
            default: begin
                w_next      = W_IDLE;
                wr_gnt_next = 2'b00;
            end
        endcase
    end

    always_comb begin
        r_next       = r_state;
        rd_gnt_next  = rd_gnt;
        rd_last_next = rd_last;
        case (r_state)
            R_IDLE: if (s0_arvalid || s1_arvalid) begin
                r_next       = R_ADDR;
                rd_gnt_next  = rd_pick ? 2'b10 : 2'b01;
                rd_last_next = rd_pick;
            end
            R_ADDR: if (m_arvalid && m_arready) r_next = R_DATA;
            R_DATA: if (m_rvalid && m_rready && m_rlast) begin
                r_next      = R_IDLE;
                rd_gnt_next = 2'b00;
            end
            default: begin
                r_next      = R_IDLE;
                rd_gnt_next = 2'b00;
            end
        endcase
    end

    // Handshake gating: only the granted port sees ready/valid, and only in its phase.
    always_comb begin
        m_awvalid  = 1'b0;
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        m_wvalid   = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        m_bready   = 1'b0;
        s0_bvalid  = 1'b0;
        s1_bvalid  = 1'b0;
        case (w_state)
            W_ADDR: begin
                m_awvalid  = wr_sel ? s1_awvalid : s0_awvalid;
                s0_awready = wr_gnt[0] & m_awready;
                s1_awready = wr_gnt[1] & m_awready;
            end
            W_DATA: begin
                m_wvalid  = wr_sel ? s1_wvalid : s0_wvalid;
                s0_wready = wr_gnt[0] & m_wready;
                s1_wready = wr_gnt[1] & m_wready;
            end
            W_RESP: begin
                m_bready  = wr_sel ? s1_bready : s0_bready;
                s0_bvalid = wr_gnt[0] & m_bvalid;
                s1_bvalid = wr_gnt[1] & m_bvalid;
            end
            default: ;
        endcase
    end

    always_comb begin
        m_arvalid  = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        m_rready   = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        case (r_state)
            R_ADDR: begin
                m_arvalid  = rd_sel ? s1_arvalid : s0_arvalid;
                s0_arready = rd_gnt[0] & m_arready;
                s1_arready = rd_gnt[1] & m_arready;
            end
            R_DATA: begin
                m_rready  = rd_sel ? s1_rready : s0_rready;
                s0_rvalid = rd_gnt[0] & m_rvalid;
                s1_rvalid = rd_gnt[1] & m_rvalid;
            end
            default: ;
        endcase
    end

    assign m_awaddr  = wr_sel ? s1_awaddr  : s0_awaddr;
    assign m_awid    = wr_sel ? s1_awid    : s0_awid;
    assign m_awlen   = wr_sel ? s1_awlen   : s0_awlen;
    assign m_awburst = wr_sel ? s1_awburst : s0_awburst;
    assign m_wlast   = wr_sel ? s1_wlast   : s0_wlast;
    assign m_wstrb   = wr_sel ? s1_wstrb   : s0_wstrb;
    assign m_wdata   = wr_sel ? s1_wdata   : s0_wdata;
    assign m_araddr  = rd_sel ? s1_araddr  : s0_araddr;
    assign m_arid    = rd_sel ? s1_arid    : s0_arid;
    assign m_arlen   = rd_sel ? s1_arlen   : s0_arlen;
    assign m_arburst = rd_sel ? s1_arburst : s0_arburst;

    assign s0_bresp = m_bresp;
    assign s0_bid   = m_bid;
    assign s1_bresp = m_bresp;
    assign s1_bid   = m_bid;
    assign s0_rlast = m_rlast;
    assign s0_rresp = m_rresp;
    assign s0_rid   = m_rid;
    assign s0_rdata = m_rdata;
    assign s1_rlast = m_rlast;
    assign s1_rresp = m_rresp;
    assign s1_rid   = m_rid;
    assign s1_rdata = m_rdata;

    assign wr_gnt_o = wr_gnt;
    assign rd_gnt_o = rd_gnt;

endmodule

// File: doc/axi_ddr3_arbiter.md
AXI_DDR3_ARBITER -- requirements
Module: axi_ddr3_arbiter

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 4: ID width on all ports; ISB = AXI_ID_WIDTH-1.
REQ-002 Parameter ADDR_WIDTH, default 27: byte-address width on all ports.
REQ-003 Parameter DATA_WIDTH, default 32: data width; STRB width = DATA_WIDTH/8.
REQ-004 clock  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sN_aw{valid,addr,id,len[7:0],burst[1:0]} in / sN_awready out, for N=0,1: upstream write-address channel.
REQ-007 sN_w{valid,last,strb,data} in / sN_wready out: upstream write-data channel.
REQ-008 sN_b{valid,resp[1:0],id} out / sN_bready in: upstream write-response channel.
REQ-009 sN_ar{valid,addr,id,len[7:0],burst[1:0]} in / sN_arready out: upstream read-address channel.
REQ-010 sN_r{valid,last,resp[1:0],id,data} out / sN_rready in: upstream read-data channel.
REQ-011 m_aw*, m_w*, m_b*, m_ar*, m_r*: single downstream AXI4 port, same fields, opposite directions, to the DDR3 core.
REQ-012 wr_gnt_o  out  2  one-hot write grant (00 = none); rd_gnt_o  out  2  one-hot read grant.

Function
REQ-013 Write and read paths SHALL arbitrate independently and concurrently; at most one outstanding write and one outstanding read.
REQ-014 Write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP.
REQ-015 W_IDLE: if any sN_awvalid, register grant, go W_ADDR next cycle; no upstream ready asserted in W_IDLE.
REQ-016 W_ADDR: granted AW forwarded combinationally to m_aw*; on m_awvalid&m_awready go W_DATA.
REQ-017 W_DATA: granted W forwarded to m_w*; on handshake with wlast=1 go W_RESP.
REQ-018 W_RESP: m_b* routed to granted port only; on bvalid&bready go W_IDLE, grant cleared.
REQ-019 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA, with R_IDLE/R_ADDR as REQ-015/016 on AR.
REQ-020 R_DATA: m_r* routed to granted port; on rvalid&rready&rlast go R_IDLE.
REQ-021 Arbitration: round-robin per path; last-winner pointer updated at grant; if both request, grant the port not last granted; single requester always wins.
REQ-022 Both pointers reset to 1 so s0 wins the first contested grant.
REQ-023 Non-granted port: awready/wready/arready = 0, bvalid/rvalid = 0; its requests held off without loss.
REQ-024 IDs, addr, len, burst, strb, data, resp SHALL pass unmodified; no ID remapping.
REQ-025 m_*valid and m_bready/m_rready SHALL be 0 whenever the owning FSM is idle or not in the corresponding phase.
REQ-026 Grant latency: request at cycle n in idle -> m_awvalid/m_arvalid at n+1; completion -> idle same edge, next grant earliest one cycle later.
REQ-027 W before AW (wvalid in W_ADDR) SHALL be stalled (wready=0) until W_DATA.

Reset
REQ-028 On reset: both FSMs to idle, grants 00, all upstream ready/valid and all downstream valid/ready outputs 0, pointers to 1.
REQ-029 Reset mid-transaction SHALL abandon it; no residual beats forwarded after reset deasserts.

Verification
REQ-030 s0 AW(addr 0x100, len 3, id 2) + 4 W beats -> m_aw seen 1 cycle after request, 4 m_w beats, last on beat 4, s0_bvalid id 2, wr_gnt_o 01 throughout.
REQ-031 s0 and s1 assert arvalid same cycle, repeatedly -> grants alternate s0,s1,s0; rd_gnt_o 01,10,01; s1 R beats never on s0.
REQ-032 Concurrent s0 write and s1 read -> both complete overlapped, wr_gnt_o 01 and rd_gnt_o 10 simultaneously.
REQ-033 m_rready stall with rlast pending, s1 rready=0 for 5 cycles -> beat held, FSM stays R_DATA, completes after rready.
REQ-034 Reset asserted in W_DATA after beat 2 of 4 -> next cycle all outputs 0, grants 00; new s1 write then completes normally.
